// File: rtl/alu_result_stage_if.sv
// ============================================================================
// Module      : alu_result_stage_if
// Description : Producer/consumer bus of the ALU result stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_result_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_result;
    logic        in_carryout;
    logic        in_overflow;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_carryout;
    logic        out_overflow;
    logic        out_zero;
    logic        out_illegal;

    modport master (
        output in_valid, in_op, in_result, in_carryout, in_overflow, in_zero, out_ready,
        input  in_ready, out_valid, out_result, out_carryout, out_overflow, out_zero, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_result, in_carryout, in_overflow, in_zero, out_ready,
        output in_ready, out_valid, out_result, out_carryout, out_overflow, out_zero, out_illegal
    );
endinterface

`default_nettype wire

// File: rtl/alu_result_stage.sv
// ============================================================================
// Module      : alu_result_stage
// Description : Registered FIFO stage behind the ALU with result sanitising,
//               illegal-op flagging and optional sticky status flags
//               (enabled by defining ALU_STICKY_FLAGS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_stage #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    alu_result_stage_if.slave     bus,
    output logic [PTR_W:0]        count,
    output logic                  sticky_carry,
    output logic                  sticky_ovf,
    input  wire logic             flag_clr
);

    localparam logic [PTR_W:0] c_full    = (PTR_W + 1)'(DEPTH);
    localparam logic [3:0]     c_max_op  = 4'b1000;

    typedef struct packed {
        logic [31:0] result;
        logic        carryout;
        logic        overflow;
        logic        zero;
        logic        illegal;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    entry_t w_entry;
    logic   w_in_ready;
    logic   w_out_valid;
    logic   w_wr;
    logic   w_rd;
    logic   w_illegal;
    logic   w_arith;

    assign w_in_ready  = (r_count != c_full);
    assign w_out_valid = (r_count != '0);
    assign w_wr        = bus.in_valid && w_in_ready;
    assign w_rd        = w_out_valid && bus.out_ready;
    assign w_illegal   = (bus.in_op > c_max_op);
    assign w_arith     = (bus.in_op == 4'b0000) || (bus.in_op == 4'b0001);

    // Flags only mean something for add/sub; illegal ops become a clean zero result.
    always_comb begin
        w_entry          = '0;
        w_entry.result   = w_illegal ? 32'h0 : bus.in_result;
        w_entry.carryout = w_arith && bus.in_carryout;
        w_entry.overflow = w_arith && bus.in_overflow;
        w_entry.zero     = w_illegal ? 1'b1 : bus.in_zero;
        w_entry.illegal  = w_illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count            = r_count;
    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_result   = r_mem[r_rd_ptr].result;
    assign bus.out_carryout = r_mem[r_rd_ptr].carryout;
    assign bus.out_overflow = r_mem[r_rd_ptr].overflow;
    assign bus.out_zero     = r_mem[r_rd_ptr].zero;
    assign bus.out_illegal  = r_mem[r_rd_ptr].illegal;

`ifdef ALU_STICKY_FLAGS_EN
    logic r_sticky_carry;
    logic r_sticky_ovf;

    // A setting write in the same cycle as flag_clr wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky_carry <= 1'b0;
            r_sticky_ovf   <= 1'b0;
        end else begin
            r_sticky_carry <= (r_sticky_carry && !flag_clr) || (w_wr && w_entry.carryout);
            r_sticky_ovf   <= (r_sticky_ovf   && !flag_clr) || (w_wr && w_entry.overflow);
        end
    end

    assign sticky_carry = r_sticky_carry;
    assign sticky_ovf   = r_sticky_ovf;
`else
    logic w_unused_flag_clr;
    assign w_unused_flag_clr = flag_clr;
    assign sticky_carry      = 1'b0;
    assign sticky_ovf        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// ============================================================================
// Module      : tb_alu_result_stage
// Description : Self-checking bench for alu_result_stage (table + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_stage;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [PTR_W:0]   count;
    logic             sticky_carry;
    logic             sticky_ovf;
    logic             flag_clr = 1'b0;

    alu_result_stage_if bus ();

    alu_result_stage #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .count        (count),
        .sticky_carry (sticky_carry),
        .sticky_ovf   (sticky_ovf),
        .flag_clr     (flag_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        cy, ov, z, ill;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] res;
        logic        cy, ov, z;
        exp_t        e;
    } vec_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic m_sc = 1'b0;
    logic m_so = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] res,
                                   input logic cy, input logic ov, input logic z);
        exp_t e;
        logic arith;
        arith = (op == 4'd0) || (op == 4'd1);
        e.ill = (op > 4'd8);
        e.res = e.ill ? 32'h0 : res;
        e.cy  = arith & cy;
        e.ov  = arith & ov;
        e.z   = e.ill ? 1'b1 : z;
        return e;
    endfunction

    // One clock cycle: check state against the model, score any pop, then advance.
    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] res,
                         input logic cy, input logic ov, input logic z,
                         input logic rdy, input logic clr, input exp_t e);
        logic acc;
        exp_t h;
        bus.in_valid    = v;
        bus.in_op       = op;
        bus.in_result   = res;
        bus.in_carryout = cy;
        bus.in_overflow = ov;
        bus.in_zero     = z;
        bus.out_ready   = rdy;
        flag_clr        = clr;
        #1;
        chk("count",        32'(count),         32'(q.size()));
        chk("in_ready",     32'(bus.in_ready),  32'(q.size() != DEPTH));
        chk("out_valid",    32'(bus.out_valid), 32'(q.size() != 0));
        chk("sticky_carry", 32'(sticky_carry),  32'(m_sc));
        chk("sticky_ovf",   32'(sticky_ovf),    32'(m_so));
        acc = v && (q.size() < DEPTH);
        if (rdy && q.size() != 0) begin
            h = q.pop_front();
            chk("out_result",   bus.out_result,          h.res);
            chk("out_carryout", 32'(bus.out_carryout),   32'(h.cy));
            chk("out_overflow", 32'(bus.out_overflow),   32'(h.ov));
            chk("out_zero",     32'(bus.out_zero),       32'(h.z));
            chk("out_illegal",  32'(bus.out_illegal),    32'(h.ill));
        end
`ifdef ALU_STICKY_FLAGS_EN
        m_sc = (m_sc & ~clr) | (acc & e.cy);
        m_so = (m_so & ~clr) | (acc & e.ov);
`endif
        if (acc) q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] op, input logic [31:0] res, input logic cy,
                      input logic ov, input logic z, input logic rdy, input logic clr);
        drive(1'b1, op, res, cy, ov, z, rdy, clr, model(op, res, cy, ov, z));
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, rdy, 1'b0, model(4'd0, 32'h0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " count"},     32'(count),            32'd0);
        chk({tag, " in_ready"},  32'(bus.in_ready),     32'd1);
        chk({tag, " out_valid"}, 32'(bus.out_valid),    32'd0);
        chk({tag, " result"},    bus.out_result,        32'd0);
        chk({tag, " flags"},     32'({bus.out_carryout, bus.out_overflow, bus.out_zero, bus.out_illegal}), 32'd0);
        chk({tag, " sticky"},    32'({sticky_carry, sticky_ovf}), 32'd0);
    endtask

    vec_t vt[9];

    initial begin
        vt[0] = '{4'h0, 32'h0000_0005, 1'b0, 1'b0, 1'b0, '{32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[1] = '{4'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0}};
        vt[2] = '{4'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0}};
        vt[3] = '{4'h2, 32'h0000_0000, 1'b1, 1'b1, 1'b1, '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0}};
        vt[4] = '{4'h8, 32'h0000_0001, 1'b1, 1'b1, 1'b0, '{32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0}};
        vt[5] = '{4'h9, 32'h0000_1234, 1'b1, 1'b1, 1'b0, '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1}};
        vt[6] = '{4'hB, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1}};
        vt[7] = '{4'hF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1}};
        vt[8] = '{4'h7, 32'h0000_A5A5, 1'b0, 1'b1, 1'b0, '{32'h0000_A5A5, 1'b0, 1'b0, 1'b0, 1'b0}};

        bus.in_valid = 1'b0; bus.in_op = 4'd0; bus.in_result = 32'd0;
        bus.in_carryout = 1'b0; bus.in_overflow = 1'b0; bus.in_zero = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write then pop
        wr(4'h0, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("single out_valid", 32'(bus.out_valid), 32'd1);
        chk("single out_result", bus.out_result, 32'd5);
        chk("single count", 32'(count), 32'd1);
        idle(1'b1);
        chk("single drained count", 32'(count), 32'd0);
        chk("single drained valid", 32'(bus.out_valid), 32'd0);

        // Fill to full, overflow attempt, full+pop, drain across wrap
        for (int i = 0; i < DEPTH; i++) wr(4'(i), 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full count", 32'(count), 32'(DEPTH));
        chk("full in_ready", 32'(bus.in_ready), 32'd0);
        wr(4'h0, 32'hBAD0_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wr(4'h0, 32'hBAD0_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("after full pop in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < DEPTH; i++) idle(1'b1);

        // Steady state: simultaneous write and read at count 2
        wr(4'h0, 32'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wr(4'h1, 32'h2001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            wr(4'(i % 3), 32'h3000 + 32'(i), 1'(i & 1), 1'(i >> 1), 1'b0, 1'b1, 1'b0);
            chk("stream count", 32'(count), 32'd2);
        end
        idle(1'b1);
        idle(1'b1);

        // Table vectors streamed with concurrent reads, then drained
        for (int i = 0; i < 9; i++)
            drive(1'b1, vt[i].op, vt[i].res, vt[i].cy, vt[i].ov, vt[i].z, 1'b1, 1'b0, vt[i].e);
        idle(1'b1);
        idle(1'b1);

        // Sticky flags: set, then clear racing a setting write
        idle(1'b1);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, model(4'd0, 32'd0, 1'b0, 1'b0, 1'b0));
        wr(4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef ALU_STICKY_FLAGS_EN
        chk("sticky set carry", 32'(sticky_carry), 32'd1);
`else
        chk("sticky off carry", 32'(sticky_carry), 32'd0);
`endif
        wr(4'h1, 32'h7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
`ifdef ALU_STICKY_FLAGS_EN
        chk("clr+set carry", 32'(sticky_carry), 32'd0);
        chk("clr+set ovf", 32'(sticky_ovf), 32'd1);
`else
        chk("sticky off ovf", 32'(sticky_ovf), 32'd0);
`endif
        idle(1'b1);

        // Asynchronous reset with three entries held
        for (int i = 0; i < 3; i++) wr(4'h0, 32'h4000 + 32'(i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre-reset count", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        q.delete();
        m_sc = 1'b0;
        m_so = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b0);
        wr(4'h0, 32'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
